// File: rtl/wb_regfile.sv
// Write-back select and 32x32 register file with write-before-read bypass and a commit counter.
// Latency: fwd bus and read ports 0 cycles, storage 1 edge; no backpressure, accepts one write per cycle.
module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        wb_ctrl,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [DATA_W-1:0] wb_pc,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [ADDR_W-1:0] wb_dst,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic              fwd_we,
    output logic [ADDR_W-1:0] fwd_dst,
    output logic [DATA_W-1:0] fwd_data,
    output logic [CNT_W-1:0]  commit_count,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int NREG = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [NREG];
    logic              we_eff;

    // Select code 11 is reserved and falls back to the ALU result.
    always_comb begin
        fwd_data = alu_result;
        case (wb_ctrl[1:0])
            2'b01:   fwd_data = mem_rdata;
            2'b10:   fwd_data = wb_pc;
            default: fwd_data = alu_result;
        endcase
    end

    assign we_eff  = wb_ctrl[2] && (wb_dst != '0);
    assign fwd_we  = we_eff;
    assign fwd_dst = wb_dst;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
            commit_count <= '0;
        end else if (we_eff) begin
            regs[wb_dst] <= fwd_data;
            commit_count <= commit_count + CNT_W'(1);
        end
    end

    // Bypass needs no zero guard: we_eff is already false for index 0.
    always_comb begin
        rs_data = regs[rs_addr];
        if (rs_addr == '0) begin
            rs_data = '0;
        end else if (we_eff && (rs_addr == wb_dst)) begin
            rs_data = fwd_data;
        end
    end

    always_comb begin
        rt_data = regs[rt_addr];
        if (rt_addr == '0) begin
            rt_data = '0;
        end else if (we_eff && (rt_addr == wb_dst)) begin
            rt_data = fwd_data;
        end
    end

    assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile; a second CNT_W=4 instance shares the inputs to exercise counter wrap.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  wb_ctrl;
    logic [31:0] mem_rdata, wb_pc, alu_result;
    logic [4:0]  wb_dst, rs_addr, rt_addr, dbg_addr;
    logic [31:0] rs_data, rt_data, fwd_data, dbg_data, commit_count;
    logic        fwd_we;
    logic [4:0]  fwd_dst;

    logic [31:0] rs_data4, rt_data4, fwd_data4, dbg_data4;
    logic        fwd_we4;
    logic [4:0]  fwd_dst4;
    logic [3:0]  commit_count4;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    wb_regfile dut (
        .clk(clk), .rst(rst), .wb_ctrl(wb_ctrl), .mem_rdata(mem_rdata),
        .wb_pc(wb_pc), .alu_result(alu_result), .wb_dst(wb_dst),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data),
        .fwd_we(fwd_we), .fwd_dst(fwd_dst), .fwd_data(fwd_data),
        .commit_count(commit_count), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    wb_regfile #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .wb_ctrl(wb_ctrl), .mem_rdata(mem_rdata),
        .wb_pc(wb_pc), .alu_result(alu_result), .wb_dst(wb_dst),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data4), .rt_data(rt_data4),
        .fwd_we(fwd_we4), .fwd_dst(fwd_dst4), .fwd_data(fwd_data4),
        .commit_count(commit_count4), .dbg_addr(dbg_addr), .dbg_data(dbg_data4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [2:0]  sel_ctrl [4];
    logic [4:0]  sel_dst  [4];
    logic [31:0] sel_val  [4];
    logic        sel_we   [4];

    initial begin
        rst = 1'b1; wb_ctrl = 3'b000; mem_rdata = '0; wb_pc = '0; alu_result = '0;
        wb_dst = '0; rs_addr = '0; rt_addr = '0; dbg_addr = '0;
        tick();
        tick();
        rst = 1'b0;
        #1;

        for (int i = 0; i < 32; i++) begin
            rs_addr = 5'(i); rt_addr = 5'(i); dbg_addr = 5'(i);
            #1;
            chk($sformatf("rst_rs%0d", i), rs_data, 32'h0);
            chk($sformatf("rst_rt%0d", i), rt_data, 32'h0);
            chk($sformatf("rst_dbg%0d", i), dbg_data, 32'h0);
        end
        chk("rst_count", commit_count, 32'd0);

        // Single write with same-cycle bypass
        wb_ctrl = 3'b100; alu_result = 32'h0000_1234; wb_dst = 5'd8;
        rs_addr = 5'd8; dbg_addr = 5'd8;
        #1;
        chk("byp_rs8", rs_data, 32'h1234);
        chk("byp_dbg8_pre", dbg_data, 32'h0);
        chk("byp_fwd_we", {31'b0, fwd_we}, 32'd1);
        chk("byp_fwd_dst", {27'b0, fwd_dst}, 32'd8);
        chk("byp_fwd_data", fwd_data, 32'h1234);
        tick();
        wb_ctrl = 3'b000;
        #1;
        chk("post_rs8", rs_data, 32'h1234);
        chk("post_dbg8", dbg_data, 32'h1234);
        chk("post_count", commit_count, 32'd1);

        // Result select coverage
        mem_rdata = 32'hDEAD_BEEF; wb_pc = 32'h0040_0008; alu_result = 32'h55;
        sel_ctrl[0] = 3'b101; sel_dst[0] = 5'd9;  sel_val[0] = 32'hDEAD_BEEF; sel_we[0] = 1'b1;
        sel_ctrl[1] = 3'b110; sel_dst[1] = 5'd10; sel_val[1] = 32'h0040_0008; sel_we[1] = 1'b1;
        sel_ctrl[2] = 3'b111; sel_dst[2] = 5'd11; sel_val[2] = 32'h55;        sel_we[2] = 1'b1;
        sel_ctrl[3] = 3'b000; sel_dst[3] = 5'd12; sel_val[3] = 32'h55;        sel_we[3] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wb_ctrl = sel_ctrl[k]; wb_dst = sel_dst[k];
            #1;
            chk($sformatf("sel%0d_fwd_data", k), fwd_data, sel_val[k]);
            chk($sformatf("sel%0d_fwd_we", k), {31'b0, fwd_we}, {31'b0, sel_we[k]});
            tick();
        end
        wb_ctrl = 3'b000;
        for (int k = 0; k < 4; k++) begin
            dbg_addr = sel_dst[k];
            #1;
            chk($sformatf("sel%0d_stored", k), dbg_data, sel_we[k] ? sel_val[k] : 32'h0);
        end
        chk("sel_count", commit_count, 32'd4);

        // Write to r0 is discarded
        wb_ctrl = 3'b101; wb_dst = 5'd0; mem_rdata = 32'hFFFF_FFFF; rs_addr = 5'd0; dbg_addr = 5'd0;
        #1;
        chk("r0_rs_same", rs_data, 32'h0);
        chk("r0_fwd_we", {31'b0, fwd_we}, 32'd0);
        chk("r0_fwd_data", fwd_data, 32'hFFFF_FFFF);
        tick();
        chk("r0_rs_next", rs_data, 32'h0);
        chk("r0_dbg_next", dbg_data, 32'h0);
        chk("r0_count", commit_count, 32'd4);

        // Back-to-back writes to r5
        wb_ctrl = 3'b100; wb_dst = 5'd5; alu_result = 32'hA; rt_addr = 5'd5; dbg_addr = 5'd5;
        #1;
        chk("b2b_rt_1", rt_data, 32'hA);
        tick();
        alu_result = 32'hB;
        #1;
        chk("b2b_rt_2", rt_data, 32'hB);
        chk("b2b_dbg_mid", dbg_data, 32'hA);
        tick();
        wb_ctrl = 3'b000;
        #1;
        chk("b2b_rt_3", rt_data, 32'hB);
        chk("b2b_dbg", dbg_data, 32'hB);
        chk("b2b_count", commit_count, 32'd6);

        // Reset wins over a simultaneous write
        rst = 1'b1; wb_ctrl = 3'b100; wb_dst = 5'd7; alu_result = 32'h77;
        rs_addr = 5'd7; rt_addr = 5'd8; dbg_addr = 5'd7;
        #1;
        chk("rstw_rs_byp", rs_data, 32'h77);
        chk("rstw_rt_stored", rt_data, 32'h1234);
        tick();
        rst = 1'b0; wb_ctrl = 3'b000;
        #1;
        chk("rstw_dbg7", dbg_data, 32'h0);
        chk("rstw_rt8", rt_data, 32'h0);
        chk("rstw_count", commit_count, 32'd0);
        chk("rstw_count4", {28'b0, commit_count4}, 32'd0);

        // Counter wrap on the 4-bit instance
        for (int k = 0; k < 16; k++) begin
            wb_ctrl = 3'b100; wb_dst = 5'(k + 1); alu_result = 32'(k);
            tick();
            if (k == 14) begin
                chk("wrap_count4_15", {28'b0, commit_count4}, 32'd15);
            end
        end
        wb_ctrl = 3'b000; dbg_addr = 5'd16;
        #1;
        chk("wrap_count4_0", {28'b0, commit_count4}, 32'd0);
        chk("wrap_count32", commit_count, 32'd16);
        chk("wrap_dbg16", dbg_data, 32'd15);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
